// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard decoder: scan-code prefixes,
// the default key table, decode FSM state encodings and a frame check helper.
package ps2_pkg;

    // Scan-code prefixes that steer the decode FSM
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BREAK = 8'hF0;

    // Default seven-key table, entry i at bits [8i+7:8i]:
    // 0=A 1=W 2=D 3=X 4=S 5=space 6=esc
    localparam logic [55:0] DEFAULT_KEY_CODES =
        {8'h76, 8'h29, 8'h1B, 8'h22, 8'h23, 8'h1D, 8'h1C};

    // Decode FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    // bits[0]=start, bits[8:1]=data LSB first, bits[9]=parity; stop sampled last.
    // Good frame: start low, odd parity over data+parity, stop high.
    function automatic logic frame_ok(input logic [9:0] bits, input logic stop);
        return ~bits[0] & (^bits[9:1]) & stop;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and filters the raw pins, samples data
// on filtered clock falling edges, checks framing/parity and abandons
// frames that stall. Everything runs on the system clock.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 20,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    // Index 0 = PS/2 clock, index 1 = PS/2 data
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q [2];
    logic [FCW-1:0] filt_cnt_d [2];
    logic           clk_prev_q;
    logic           fall;

    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [9:0]     shift_q, shift_d;
    logic [TW-1:0]  idle_q, idle_d;
    logic [7:0]     byte_q, byte_d;
    logic           byte_valid_q, byte_valid_d;
    logic           frame_err_q, frame_err_d;

    // Two-flop synchroniser per pin; idle bus level is high
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            // NOTE: state updates use <= so every flop samples pre-edge values;
            // blocking = here would collapse the synchroniser to one stage.
            sync1_q <= {ps2_data_i, ps2_clk_i};
            sync2_q <= sync1_q;
        end
    end

    // Stability filter: output follows input only after FILT_LEN differing cycles
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // NOTE: every combinational output gets a default first so no
            // path leaves it unassigned and no latch is inferred.
            filt_d[p]     = filt_q[p];
            filt_cnt_d[p] = '0;
            if (sync2_q[p] != filt_q[p]) begin
                if (filt_cnt_q[p] == FCW'(FILT_LEN - 1)) begin
                    filt_d[p] = sync2_q[p];
                end else begin
                    filt_cnt_d[p] = filt_cnt_q[p] + FCW'(1);
                end
            end
        end
    end

    // Filter state and previous filtered clock for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            filt_q        <= 2'b11;
            filt_cnt_q[0] <= '0;
            filt_cnt_q[1] <= '0;
            clk_prev_q    <= 1'b1;
        end else begin
            filt_q        <= filt_d;
            filt_cnt_q[0] <= filt_cnt_d[0];
            filt_cnt_q[1] <= filt_cnt_d[1];
            clk_prev_q    <= filt_q[0];
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];

    // Bit collection, frame check on the stop bit, and mid-frame timeout
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        idle_d       = idle_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (fall) begin
            idle_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (frame_ok(shift_q, filt_q[1])) begin
                    byte_valid_d = 1'b1;
                    byte_d       = shift_q[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {filt_q[1], shift_q[9:1]};
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
                bit_cnt_d   = 4'd0;
                idle_d      = '0;
                frame_err_d = 1'b1;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    // Frame state registers; a partial frame is discarded on reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            idle_q       <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            idle_q       <= idle_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: turns received scan-code bytes into a held-key bitmap
// and a buffered make/break event stream with a valid/ready interface.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int                  N_KEYS      = 7,
    parameter logic [N_KEYS*8-1:0] KEY_CODES   = DEFAULT_KEY_CODES,
    parameter logic [N_KEYS-1:0]   KEY_EXT     = '0,
    parameter int                  FILT_LEN    = 20,
    parameter int                  TIMEOUT_CYC = 200000,
    parameter int                  FIFO_DEPTH  = 4,
    localparam int                 KW          = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              PS2_CLK,
    input  logic              PS2_DATA,
    output logic [N_KEYS-1:0] keys_down,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [KW-1:0]     ev_key,
    output logic              ev_make,
    output logic              frame_err,
    output logic              overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_err;

    logic [1:0]        state_q, state_d;
    logic [N_KEYS-1:0] keys_q, keys_d;
    logic              push_q, push_d;
    logic [KW-1:0]     push_key_q, push_key_d;
    logic              push_make_q, push_make_d;

    logic              lk_ext, lk_make, do_lookup;
    logic              hit;
    logic [KW-1:0]     hit_idx;

    logic [KW:0]       mem_q [FIFO_DEPTH];
    logic [KW:0]       head;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              empty, full, pop, push_ok;
    logic              overflow_q, overflow_d;
    logic [KW-1:0]     hold_key_q, hold_key_d;
    logic              hold_make_q, hold_make_d;

    ps2_frame_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_i        (CLK),
        .rst_n_i      (RST_N),
        .ps2_clk_i    (PS2_CLK),
        .ps2_data_i   (PS2_DATA),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_err)
    );

    assign lk_ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign lk_make = (state_q == ST_IDLE) || (state_q == ST_EXT);

    // Key table match: lowest index whose code and extended flag both match
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[8*i +: 8] == rx_byte && KEY_EXT[i] == lk_ext) begin
                hit     = 1'b1;
                hit_idx = KW'(i);
            end
        end
    end

    // Decode FSM: prefixes steer state, final byte updates keys and queues an event
    always_comb begin
        state_d     = state_q;
        keys_d      = keys_q;
        push_d      = 1'b0;
        push_key_d  = push_key_q;
        push_make_d = push_make_q;
        do_lookup   = 1'b0;
        if (rx_err) begin
            state_d = ST_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == CODE_EXT)        state_d = ST_EXT;
                    else if (rx_byte == CODE_BREAK) state_d = ST_BRK;
                    else                            do_lookup = 1'b1;
                end
                ST_EXT: begin
                    if (rx_byte == CODE_BREAK) state_d = ST_EXT_BRK;
                    else                       do_lookup = 1'b1;
                end
                default: do_lookup = 1'b1;
            endcase
        end
        if (do_lookup) begin
            state_d = ST_IDLE;
            // Only a change of held state is an event; typematic repeats and
            // releases of keys not held fall through silently.
            if (hit && (lk_make != keys_q[hit_idx])) begin
                keys_d[hit_idx] = lk_make;
                push_d          = 1'b1;
                push_key_d      = hit_idx;
                push_make_d     = lk_make;
            end
        end
    end

    // Decode state, key bitmap and the one-cycle event staging register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            keys_q      <= '0;
            push_q      <= 1'b0;
            push_key_q  <= '0;
            push_make_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            keys_q      <= keys_d;
            push_q      <= push_d;
            push_key_q  <= push_key_d;
            push_make_q <= push_make_d;
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && ev_ready;
    assign push_ok = push_q && (!full || pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // FIFO pointers, sticky overflow and the last-popped head for the empty case
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        hold_key_d  = hold_key_q;
        hold_make_d = hold_make_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            hold_key_d  = head[KW-1:0];
            hold_make_d = head[KW];
        end
        if (push_q && full && !pop) overflow_d = 1'b1;
    end

    // FIFO control registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            hold_key_q  <= '0;
            hold_make_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            hold_key_q  <= hold_key_d;
            hold_make_q <= hold_make_d;
        end
    end

    // FIFO storage, written on accepted push
    always_ff @(posedge CLK) begin
        // NOTE: storage is not reset; outputs only expose it while the
        // pointers say it holds a valid entry.
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {push_make_q, push_key_q};
    end

    assign keys_down = keys_q;
    assign ev_valid  = !empty;
    assign ev_key    = empty ? hold_key_q  : head[KW-1:0];
    assign ev_make   = empty ? hold_make_q : head[KW];
    assign frame_err = rx_err;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-bangs PS/2 frames and checks the
// key bitmap, event FIFO, error pulses and overflow against hand-derived values.
module tb_ps2_key_decoder;

    localparam int N_KEYS      = 7;
    localparam int FILT_LEN    = 4;
    localparam int TIMEOUT_CYC = 400;
    localparam int FIFO_DEPTH  = 4;
    localparam int HALF        = 20;

    logic              CLK      = 1'b0;
    logic              RST_N    = 1'b0;
    logic              PS2_CLK  = 1'b1;
    logic              PS2_DATA = 1'b1;
    logic              ev_ready = 1'b0;
    logic [N_KEYS-1:0] keys_down;
    logic              ev_valid;
    logic [2:0]        ev_key;
    logic              ev_make;
    logic              frame_err;
    logic              overflow;

    int total   = 0;
    int bad     = 0;
    int err_cnt = 0;
    int e0;

    ps2_key_decoder #(
        .N_KEYS      (N_KEYS),
        .KEY_EXT     (7'b1000000),
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .keys_down (keys_down),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_key    (ev_key),
        .ev_make   (ev_make),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 CLK = ~CLK;

    // Count every cycle frame_err is high so pulse width is visible
    always @(negedge CLK) if (frame_err) err_cnt++;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        PS2_DATA = b;
        cycles(HALF);
        PS2_CLK = 1'b0;
        cycles(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~(^d) ^ flip_par);
        send_bit(1'b1);
        PS2_DATA = 1'b1;
        cycles(HALF);
    endtask

    task automatic pop_check(input string tag, input logic [2:0] key, input logic make);
        check({tag, ".valid"}, ev_valid, 1);
        check({tag, ".key"},   ev_key,   key);
        check({tag, ".make"},  ev_make,  make);
        ev_ready = 1'b1;
        @(negedge CLK);
        ev_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        cycles(3);
        check("rst.keys",  keys_down, 0);
        check("rst.valid", ev_valid,  0);
        check("rst.err",   frame_err, 0);
        check("rst.ovf",   overflow,  0);
        RST_N = 1'b1;
        cycles(2);

        // Plain make then break of key 0
        send_frame(8'h1C, 1'b0);
        check("a_make.keys", keys_down, 7'b0000001);
        pop_check("a_make", 3'd0, 1'b1);
        check("a_make.empty", ev_valid, 0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("a_brk.keys", keys_down, 0);
        pop_check("a_brk", 3'd0, 1'b0);

        // Key 6 only matches after E0
        send_frame(8'h76, 1'b0);
        check("esc_plain.keys",  keys_down, 0);
        check("esc_plain.valid", ev_valid,  0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h76, 1'b0);
        check("esc_ext.keys", keys_down, 7'b1000000);
        pop_check("esc_make", 3'd6, 1'b1);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h76, 1'b0);
        check("esc_brk.keys", keys_down, 0);
        pop_check("esc_brk", 3'd6, 1'b0);

        // Typematic repeats of key 1 give a single make
        for (int r = 0; r < 3; r++) begin
            send_frame(8'h1D, 1'b0);
            check("rep.keys", keys_down, 7'b0000010);
        end
        pop_check("rep_make", 3'd1, 1'b1);
        check("rep.single", ev_valid, 0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1D, 1'b0);
        pop_check("rep_brk", 3'd1, 1'b0);
        check("rep_brk.empty", ev_valid, 0);

        // Bad parity frame then a good one
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        check("par.err_pulse", err_cnt - e0, 1);
        check("par.valid",     ev_valid,     0);
        check("par.keys",      keys_down,    0);
        send_frame(8'h1C, 1'b0);
        check("par_next.keys", keys_down, 7'b0000001);
        pop_check("par_next", 3'd0, 1'b1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        pop_check("par_next_brk", 3'd0, 1'b0);

        // Partial frame abandoned by timeout
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        PS2_DATA = 1'b1;
        for (int i = 0; i < TIMEOUT_CYC + 100 && err_cnt == e0; i++) @(negedge CLK);
        cycles(2);
        check("tmo.err_pulse", err_cnt - e0, 1);
        check("tmo.valid",     ev_valid,     0);
        send_frame(8'h23, 1'b0);
        check("tmo_next.keys", keys_down, 7'b0000100);
        pop_check("tmo_next", 3'd2, 1'b1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h23, 1'b0);
        pop_check("tmo_next_brk", 3'd2, 1'b0);

        // Overflow: five makes into a four-entry FIFO with no consumer
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1D, 1'b0);
        send_frame(8'h23, 1'b0);
        send_frame(8'h22, 1'b0);
        check("ovf.before", overflow, 0);
        send_frame(8'h1B, 1'b0);
        check("ovf.flag", overflow,  1);
        check("ovf.keys", keys_down, 7'b0011111);
        for (int k = 0; k < 4; k++) pop_check("ovf_pop", 3'(k), 1'b1);
        check("ovf.drained", ev_valid, 0);
        check("ovf.hold",    ev_key,   3);
        check("ovf.sticky",  overflow, 1);

        // One-cycle reset clears everything
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        check("rst2.keys",  keys_down, 0);
        check("rst2.valid", ev_valid,  0);
        check("rst2.key",   ev_key,    0);
        check("rst2.make",  ev_make,   0);
        check("rst2.err",   frame_err, 0);
        check("rst2.ovf",   overflow,  0);

        // Protocol bytes with no table entry are ignored
        send_frame(8'hAA, 1'b0);
        check("aa.valid", ev_valid,  0);
        check("aa.keys",  keys_down, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
